// File: rtl/uart_rx_fifo_if.sv
// Host-side bundle for the UART receiver: serial line, pop/clear/irq-enable
// controls and the FIFO status/data outputs.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
);
  logic                     i_UART_TX;
  logic                     i_pop;
  logic                     i_clear_errors;
  logic                     i_irq_enable;
  logic [7:0]               o_rxdata;
  logic                     o_data_ready;
  logic [FIFO_DEPTH_LOG2:0] o_level;
  logic                     o_overrun;
  logic                     o_frame_error;
  logic                     o_irq;

  modport master (
    output i_UART_TX, i_pop, i_clear_errors, i_irq_enable,
    input  o_rxdata, o_data_ready, o_level, o_overrun, o_frame_error, o_irq
  );

  modport slave (
    input  i_UART_TX, i_pop, i_clear_errors, i_irq_enable,
    output o_rxdata, o_data_ready, o_level, o_overrun, o_frame_error, o_irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through receive buffer.
// Macro UART_RX_FIFO_EN selects a 2**FIFO_DEPTH_LOG2 FIFO; otherwise a single holding register.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synchronized line
// START | counting to start-bit centre, rejecting glitches
// DATA  | sampling 8 data bits at bit centres, LSB first
// STOP  | sampling stop bit; high pushes the byte, low flags a frame error
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT    = 69,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);

  localparam int LW = FIFO_DEPTH_LOG2 + 1;
  localparam logic [11:0] HALF_LOAD = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0] BIT_LOAD  = 12'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic        rx;
  logic [11:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        push_q, push_d;
  logic        baud_tc;
  logic        frame_evt;

  assign rx      = sync_q[1];
  assign baud_tc = (baud_q == 12'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      baud_q  <= 12'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], bus.i_UART_TX};
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      push_q  <= push_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    frame_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d = START;
          bit_d   = 3'd0;
          baud_d  = HALF_LOAD;
        end
      end
      START: begin
        if (!baud_tc) begin
          baud_d = baud_q - 12'd1;
        end else if (rx) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          baud_d  = BIT_LOAD;
        end
      end
      DATA: begin
        if (!baud_tc) begin
          baud_d = baud_q - 12'd1;
        end else begin
          shift_d = {rx, shift_q[7:1]};
          baud_d  = BIT_LOAD;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        // Leaving at the stop-bit centre lets a back-to-back start bit be caught.
        if (!baud_tc) begin
          baud_d = baud_q - 12'd1;
        end else begin
          state_d = IDLE;
          if (rx) push_d    = 1'b1;
          else    frame_evt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic          do_pop, do_push, overrun_evt;
  logic [LW-1:0] level;
  logic [7:0]    head;

`ifdef UART_RX_FIFO_EN
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic          full;

  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = bus.i_pop && (level_q != '0);
  // A coincident pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_q && (!full || do_pop);
  assign level   = level_q;
  assign head    = mem[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end
`else
  logic [7:0] hold_q;
  logic       full_q;

  assign do_pop  = bus.i_pop && full_q;
  assign do_push = push_q && (!full_q || do_pop);
  assign level   = {{(LW-1){1'b0}}, full_q};
  assign head    = hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= 8'h00;
      full_q <= 1'b0;
    end else if (do_push) begin
      hold_q <= shift_q;
      full_q <= 1'b1;
    end else if (do_pop) begin
      full_q <= 1'b0;
    end
  end
`endif

  assign overrun_evt = push_q && !do_push;

  logic overrun_q, frame_err_q, irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (overrun_evt)             overrun_q <= 1'b1;
      else if (bus.i_clear_errors) overrun_q <= 1'b0;
      if (frame_evt)               frame_err_q <= 1'b1;
      else if (bus.i_clear_errors) frame_err_q <= 1'b0;
      irq_q <= bus.i_irq_enable && ((level != '0) || overrun_q || frame_err_q);
    end
  end

  assign bus.o_rxdata      = (level != '0) ? head : 8'h00;
  assign bus.o_data_ready  = (level != '0);
  assign bus.o_level       = level;
  assign bus.o_overrun     = overrun_q;
  assign bus.o_frame_error = frame_err_q;
  assign bus.o_irq         = irq_q;

endmodule
